// File: rtl/volume_ctrl_if.sv
// Button inputs and pulse/status outputs of the volume attenuator front-end.
// The controller connects through the master modport, the driving side through slave.
interface volume_ctrl_if #(
  parameter int level_width_p = 3
) ();

  logic                     up_btn_i;
  logic                     down_btn_i;
  logic                     mute_btn_i;
  logic                     up_o;
  logic                     down_o;
  logic [level_width_p-1:0] level_o;
  logic                     muted_o;
  logic                     busy_o;

  modport master (
    input  up_btn_i,
    input  down_btn_i,
    input  mute_btn_i,
    output up_o,
    output down_o,
    output level_o,
    output muted_o,
    output busy_o
  );

  modport slave (
    output up_btn_i,
    output down_btn_i,
    output mute_btn_i,
    input  up_o,
    input  down_o,
    input  level_o,
    input  muted_o,
    input  busy_o
  );

endinterface

// File: rtl/volume_ctrl.sv
// Conditions raw up/down/mute buttons and sequences rate-limited up/down pulses
// into the volume attenuator, with stepped mute/unmute ramps and a shadow level.
module volume_ctrl #(
  parameter int debounce_cycles_p = 4,
  parameter int step_gap_p        = 8,
  parameter int min_level_p       = 1,
  parameter int max_level_p       = 7,
  parameter int level_width_p     = 3
) (
  input logic           clk_i,
  input logic           reset_i,
  volume_ctrl_if.master bus
);

  localparam int DB_W  = $clog2(debounce_cycles_p) + 1;
  localparam int GAP_W = $clog2(step_gap_p) + 1;

  localparam logic [DB_W-1:0]          DB_LAST  = DB_W'(debounce_cycles_p - 1);
  localparam logic [GAP_W-1:0]         GAP_LAST = GAP_W'(step_gap_p - 1);
  localparam logic [level_width_p-1:0] MAX_L    = level_width_p'(max_level_p);
  localparam logic [level_width_p-1:0] MIN_L    = level_width_p'(min_level_p);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_GAP         = 3'd1;
  localparam logic [2:0] S_MUTE_RAMP   = 3'd2;
  localparam logic [2:0] S_MUTED       = 3'd3;
  localparam logic [2:0] S_UNMUTE_RAMP = 3'd4;

  // Button vectors are ordered {mute, down, up}.
  logic [2:0]            w_raw;
  logic [2:0]            r_sync1;
  logic [2:0]            r_sync2;
  logic [2:0]            r_db_level;
  logic [2:0]            r_db_prev;
  logic [2:0][DB_W-1:0]  r_db_cnt;
  logic [2:0]            w_ev;
  logic                  w_ev_up;
  logic                  w_ev_down;
  logic                  w_ev_mute;

  logic [2:0]               r_state;
  logic [2:0]               r_ret;
  logic [GAP_W-1:0]         r_gap_cnt;
  logic [level_width_p-1:0] r_level;
  logic [level_width_p-1:0] r_saved;
  logic [level_width_p-1:0] w_unmute_floor;
  logic                     r_up;
  logic                     r_down;

  assign w_raw = {bus.mute_btn_i, bus.down_btn_i, bus.up_btn_i};

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted once the synchronized input has disagreed with it
  // for debounce_cycles_p samples in a row; any agreeing sample restarts the count.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_db_level <= '0;
      r_db_prev  <= '0;
      r_db_cnt   <= '0;
    end else begin
      r_db_prev <= r_db_level;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_level[i] <= r_sync2[i];
          r_db_cnt[i]   <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_ev      = r_db_level & ~r_db_prev;
  assign w_ev_up   = w_ev[0];
  assign w_ev_down = w_ev[1];
  assign w_ev_mute = w_ev[2];

  assign w_unmute_floor = (r_saved > MIN_L) ? r_saved : MIN_L;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state   <= S_IDLE;
      r_ret     <= S_IDLE;
      r_gap_cnt <= '0;
      r_level   <= '0;
      r_saved   <= '0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ev_mute) begin
            r_saved <= r_level;
            r_state <= S_MUTE_RAMP;
          end else if (w_ev_up && !w_ev_down && (r_level < MAX_L)) begin
            r_up      <= 1'b1;
            r_level   <= r_level + 1'b1;
            r_ret     <= S_IDLE;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else if (w_ev_down && !w_ev_up && (r_level > MIN_L)) begin
            r_down    <= 1'b1;
            r_level   <= r_level - 1'b1;
            r_ret     <= S_IDLE;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end
        // Events seen here are intentionally lost, not queued.
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= r_ret;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        S_MUTE_RAMP: begin
          if (r_level < MAX_L) begin
            r_up      <= 1'b1;
            r_level   <= r_level + 1'b1;
            r_ret     <= S_MUTE_RAMP;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            r_state <= S_MUTED;
          end
        end
        S_MUTED: begin
          if (w_ev_mute) begin
            r_state <= S_UNMUTE_RAMP;
          end
        end
        S_UNMUTE_RAMP: begin
          if (r_level > w_unmute_floor) begin
            r_down    <= 1'b1;
            r_level   <= r_level - 1'b1;
            r_ret     <= S_UNMUTE_RAMP;
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.up_o    = r_up;
  assign bus.down_o  = r_down;
  assign bus.level_o = r_level;
  assign bus.muted_o = (r_state == S_MUTED);
  assign bus.busy_o  = (r_state != S_IDLE) && (r_state != S_MUTED);

  a_pulse_exclusive: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(r_up && r_down));

  a_pulse_spacing: assert property (@(posedge clk_i) disable iff (!reset_i)
    (r_up || r_down) |=> !(r_up || r_down));

  a_level_range: assert property (@(posedge clk_i) disable iff (!reset_i)
    r_level <= MAX_L);

endmodule
